// File: rtl/itch_msg_decoder.sv
// itch_msg_decoder: ITCH 5.0 byte-stream decoder for MoldUDP64 message blocks.
//
// Decodes 'A' (add), 'F' (add with MPID, optional), 'D' (delete) and 'E' (executed) messages
// and skips every other type. Framing and format errors are counted.
//
// Ports
//   clkIn         single clock
//   rstIn         synchronous, active-high reset
//   dataIn        payload byte
//   validIn       dataIn valid this cycle; every valid byte is consumed
//   lastIn        with validIn: final byte of the UDP payload
//   addValidOut   1-cycle pulse: add order decoded
//   delValidOut   1-cycle pulse: order delete decoded
//   execValidOut  1-cycle pulse: order executed decoded
//   refNumOut     order reference number
//   locateOut     stock locate
//   priceOut      add: price; del/exec: 0
//   sharesOut     add: shares; exec: executed shares; del: 0
//   buySellOut    add: 1 = buy, 0 = sell; del/exec: 0
//   errCountOut   saturating error count
module itch_msg_decoder #(
    parameter bit ADD_MPID_EN   = 1'b1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic [7:0]               dataIn,
    input  logic                     validIn,
    input  logic                     lastIn,
    output logic                     addValidOut,
    output logic                     delValidOut,
    output logic                     execValidOut,
    output logic [63:0]              refNumOut,
    output logic [15:0]              locateOut,
    output logic [31:0]              priceOut,
    output logic [31:0]              sharesOut,
    output logic                     buySellOut,
    output logic [ERR_CNT_WIDTH-1:0] errCountOut
);
    typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY} state_t;
    typedef enum logic [1:0] {K_SKIP, K_ADD, K_DEL, K_EXEC} kind_t;

    state_t                   state_q, state_d;
    kind_t                    kind_q, kind_d, type_kind, cur_kind;
    logic [15:0]              len_q, len_d, idx_q, idx_d;
    logic                     bad_q, bad_d;
    logic [63:0]              ref_acc_q, ref_acc_d;
    logic [15:0]              loc_acc_q, loc_acc_d;
    logic [31:0]              price_acc_q, price_acc_d;
    logic [31:0]              shares_acc_q, shares_acc_d;
    logic                     bs_acc_q, bs_acc_d;
    logic                     add_q, add_d, del_q, del_d, exec_q, exec_d;
    logic [63:0]              ref_q, ref_d;
    logic [15:0]              loc_q, loc_d;
    logic [31:0]              price_q, price_d, shares_q, shares_d;
    logic                     bs_q, bs_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     known_type, err_inc, last_byte;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        kind_d       = kind_q;
        bad_d        = bad_q;
        ref_acc_d    = ref_acc_q;
        loc_acc_d    = loc_acc_q;
        price_acc_d  = price_acc_q;
        shares_acc_d = shares_acc_q;
        bs_acc_d     = bs_acc_q;
        add_d        = 1'b0;
        del_d        = 1'b0;
        exec_d       = 1'b0;
        ref_d        = ref_q;
        loc_d        = loc_q;
        price_d      = price_q;
        shares_d     = shares_q;
        bs_d         = bs_q;
        err_inc      = 1'b0;
        // Type and length are only both known at body byte 0, where len_q is final
        known_type   = dataIn == 8'h41 || dataIn == 8'h44 || dataIn == 8'h45 ||
                       (ADD_MPID_EN && dataIn == 8'h46);
        type_kind    = (dataIn == 8'h41 && len_q == 16'd36) ||
                       (ADD_MPID_EN && dataIn == 8'h46 && len_q == 16'd40) ? K_ADD  :
                       (dataIn == 8'h44 && len_q == 16'd19)                 ? K_DEL  :
                       (dataIn == 8'h45 && len_q == 16'd31)                 ? K_EXEC : K_SKIP;
        cur_kind     = (idx_q == 16'd0) ? type_kind : kind_q;
        last_byte    = idx_q == len_q - 16'd1;
        if (validIn) begin
            case (state_q)
                LEN_HI: begin
                    len_d   = {dataIn, 8'h00};
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d   = {len_q[15:8], dataIn};
                    idx_d   = 16'd0;
                    kind_d  = K_SKIP;
                    bad_d   = 1'b0;
                    err_inc = lastIn;
                    state_d = (lastIn || len_d == 16'd0) ? LEN_HI : BODY;
                end
                BODY: begin
                    if (idx_q == 16'd0) begin
                        kind_d = type_kind;
                        if (known_type && type_kind == K_SKIP) begin
                            bad_d   = 1'b1;
                            err_inc = 1'b1;
                        end
                    end
                    if (cur_kind != K_SKIP) begin
                        if (idx_q >= 16'd1 && idx_q <= 16'd2)
                            loc_acc_d = {loc_acc_q[7:0], dataIn};
                        if (idx_q >= 16'd11 && idx_q <= 16'd18)
                            ref_acc_d = {ref_acc_q[55:0], dataIn};
                    end
                    if (cur_kind == K_ADD) begin
                        if (idx_q >= 16'd20 && idx_q <= 16'd23)
                            shares_acc_d = {shares_acc_q[23:0], dataIn};
                        if (idx_q >= 16'd32 && idx_q <= 16'd35)
                            price_acc_d = {price_acc_q[23:0], dataIn};
                        if (idx_q == 16'd19) begin
                            bs_acc_d = dataIn == 8'h42;
                            if (dataIn != 8'h42 && dataIn != 8'h53) begin
                                bad_d   = 1'b1;
                                err_inc = 1'b1;
                            end
                        end
                    end
                    if (cur_kind == K_EXEC && idx_q >= 16'd19 && idx_q <= 16'd22)
                        shares_acc_d = {shares_acc_q[23:0], dataIn};
                    if (last_byte) begin
                        state_d = LEN_HI;
                        if (cur_kind != K_SKIP && !bad_d) begin
                            add_d    = cur_kind == K_ADD;
                            del_d    = cur_kind == K_DEL;
                            exec_d   = cur_kind == K_EXEC;
                            ref_d    = ref_acc_d;
                            loc_d    = loc_acc_d;
                            price_d  = cur_kind == K_ADD ? price_acc_d : 32'd0;
                            shares_d = cur_kind == K_DEL ? 32'd0 : shares_acc_d;
                            bs_d     = cur_kind == K_ADD && bs_acc_d;
                        end
                    end else if (lastIn) begin
                        // Truncated message; a message already counted as bad is not counted twice
                        state_d = LEN_HI;
                        if (!bad_d) err_inc = 1'b1;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
                default: state_d = LEN_HI;
            endcase
        end
        err_d = (err_inc && !(&err_q)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            idx_q        <= '0;
            kind_q       <= K_SKIP;
            bad_q        <= 1'b0;
            ref_acc_q    <= '0;
            loc_acc_q    <= '0;
            price_acc_q  <= '0;
            shares_acc_q <= '0;
            bs_acc_q     <= 1'b0;
            add_q        <= 1'b0;
            del_q        <= 1'b0;
            exec_q       <= 1'b0;
            ref_q        <= '0;
            loc_q        <= '0;
            price_q      <= '0;
            shares_q     <= '0;
            bs_q         <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            kind_q       <= kind_d;
            bad_q        <= bad_d;
            ref_acc_q    <= ref_acc_d;
            loc_acc_q    <= loc_acc_d;
            price_acc_q  <= price_acc_d;
            shares_acc_q <= shares_acc_d;
            bs_acc_q     <= bs_acc_d;
            add_q        <= add_d;
            del_q        <= del_d;
            exec_q       <= exec_d;
            ref_q        <= ref_d;
            loc_q        <= loc_d;
            price_q      <= price_d;
            shares_q     <= shares_d;
            bs_q         <= bs_d;
            err_q        <= err_d;
        end
    end

    assign addValidOut  = add_q;
    assign delValidOut  = del_q;
    assign execValidOut = exec_q;
    assign refNumOut    = ref_q;
    assign locateOut    = loc_q;
    assign priceOut     = price_q;
    assign sharesOut    = shares_q;
    assign buySellOut   = bs_q;
    assign errCountOut  = err_q;
endmodule

// File: tb/tb_itch_msg_decoder.sv
// tb_itch_msg_decoder: random and directed ITCH streams against a message-level reference model.
module tb_itch_msg_decoder;
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] refn;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        bs;
        logic [31:0] pos;
    } ev_t;

    logic        clkIn = 1'b0, rstIn = 1'b0, validIn = 1'b0, lastIn = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        a0, d0, x0, bs0, a1, d1, x1, bs1;
    logic [63:0] ref0, ref1;
    logic [15:0] loc0, loc1, err0;
    logic [31:0] pr0, pr1, sh0, sh1;
    logic [1:0]  err1;

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [7:0] sb[$], mb[$];
    bit         sl[$];
    ev_t        exp_q[$], obs0[$], obs1[$], o0, o1;
    int         acc_cyc[$];
    logic [7:0] kts[4] = '{8'h41, 8'h44, 8'h45, 8'h46};

    itch_msg_decoder #(.ADD_MPID_EN(1'b1), .ERR_CNT_WIDTH(16)) dut0 (
        .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .validIn(validIn), .lastIn(lastIn),
        .addValidOut(a0), .delValidOut(d0), .execValidOut(x0), .refNumOut(ref0),
        .locateOut(loc0), .priceOut(pr0), .sharesOut(sh0), .buySellOut(bs0), .errCountOut(err0));

    itch_msg_decoder #(.ADD_MPID_EN(1'b0), .ERR_CNT_WIDTH(2)) dut1 (
        .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .validIn(validIn), .lastIn(lastIn),
        .addValidOut(a1), .delValidOut(d1), .execValidOut(x1), .refNumOut(ref1),
        .locateOut(loc1), .priceOut(pr1), .sharesOut(sh1), .buySellOut(bs1), .errCountOut(err1));

    always #5 clkIn = ~clkIn;
    always @(posedge clkIn) cyc <= cyc + 1;

    always @(negedge clkIn) begin
        if (validIn && !rstIn) acc_cyc.push_back(cyc);
        if (a0 | d0 | x0) begin
            o0.kind   = (int'(a0) + int'(d0) + int'(x0) != 1) ? 2'd0 : a0 ? 2'd1 : d0 ? 2'd2 : 2'd3;
            o0.refn   = ref0;
            o0.loc    = loc0;
            o0.price  = pr0;
            o0.shares = sh0;
            o0.bs     = bs0;
            o0.pos    = cyc;
            obs0.push_back(o0);
        end
        if (a1 | d1 | x1) begin
            o1.kind   = (int'(a1) + int'(d1) + int'(x1) != 1) ? 2'd0 : a1 ? 2'd1 : d1 ? 2'd2 : 2'd3;
            o1.refn   = ref1;
            o1.loc    = loc1;
            o1.price  = pr1;
            o1.shares = sh1;
            o1.bs     = bs1;
            o1.pos    = cyc;
            obs1.push_back(o1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void put_be(input int off, input logic [63:0] val, input int n);
        for (int k = 0; k < n; k++) mb[off+k] = 8'(val >> (8 * (n - 1 - k)));
    endfunction

    function automatic logic [63:0] be(input int off, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[55:0], mb[off+k]};
        return v;
    endfunction

    function automatic void mk_rand(input logic [7:0] t, input int n);
        mb.delete();
        for (int k = 0; k < n; k++) mb.push_back(8'($urandom));
        mb[0] = t;
    endfunction

    function automatic void mk_add(input logic [7:0] t, input logic [15:0] loc, input logic [63:0] r,
                                   input logic [7:0] bs, input logic [31:0] sh, input logic [31:0] pr);
        mk_rand(t, t == 8'h46 ? 40 : 36);
        put_be(1, 64'(loc), 2);
        put_be(11, r, 8);
        mb[19] = bs;
        put_be(20, 64'(sh), 4);
        put_be(32, 64'(pr), 4);
    endfunction

    function automatic void mk_del(input logic [15:0] loc, input logic [63:0] r);
        mk_rand(8'h44, 19);
        put_be(1, 64'(loc), 2);
        put_be(11, r, 8);
    endfunction

    function automatic void mk_exec(input logic [15:0] loc, input logic [63:0] r, input logic [31:0] sh);
        mk_rand(8'h45, 31);
        put_be(1, 64'(loc), 2);
        put_be(11, r, 8);
        put_be(19, 64'(sh), 4);
    endfunction

    // trunc: -1 complete, -2 lastIn on the low length byte, else lastIn on that body index
    task automatic emit(input int trunc, input bit endp);
        int n = mb.size();
        sb.push_back(8'(n >> 8));
        sl.push_back(1'b0);
        sb.push_back(8'(n));
        sl.push_back(trunc == -2);
        if (trunc == -2) return;
        for (int k = 0; k < n; k++) begin
            sb.push_back(mb[k]);
            if (k == trunc) begin
                sl.push_back(1'b1);
                return;
            end
            sl.push_back(endp && k == n - 1);
        end
    endtask

    // Walks the byte stream message by message and lists the events and errors it should produce
    function automatic int model(input bit en);
        int i = 0, n = sb.size(), errs = 0;
        logic [15:0] len;
        logic [7:0]  t;
        bit          trunc, known, match, bad, isadd;
        ev_t         e;
        exp_q.delete();
        while (i < n) begin
            len[15:8] = sb[i];
            i++;
            if (i >= n) break;
            len[7:0] = sb[i];
            i++;
            if (sl[i-1]) begin
                errs++;
                continue;
            end
            if (len == 16'd0) continue;
            mb.delete();
            trunc = 1'b0;
            while (mb.size() < int'(len) && i < n && !trunc) begin
                mb.push_back(sb[i]);
                trunc = sl[i] && mb.size() < int'(len);
                i++;
            end
            if (!trunc && mb.size() < int'(len)) break;
            t     = mb[0];
            known = t == 8'h41 || t == 8'h44 || t == 8'h45 || (en && t == 8'h46);
            match = (t == 8'h41 && len == 16'd36) || (en && t == 8'h46 && len == 16'd40) ||
                    (t == 8'h44 && len == 16'd19) || (t == 8'h45 && len == 16'd31);
            bad   = known && !match;
            isadd = match && (t == 8'h41 || t == 8'h46);
            if (isadd && mb.size() > 19 && mb[19] != 8'h42 && mb[19] != 8'h53) bad = 1'b1;
            if (bad || trunc) begin
                errs++;
                continue;
            end
            if (!match) continue;
            e.kind   = isadd ? 2'd1 : t == 8'h44 ? 2'd2 : 2'd3;
            e.refn   = be(11, 8);
            e.loc    = 16'(be(1, 2));
            e.price  = isadd ? 32'(be(32, 4)) : 32'd0;
            e.shares = isadd ? 32'(be(20, 4)) : t == 8'h45 ? 32'(be(19, 4)) : 32'd0;
            e.bs     = isadd && mb[19] == 8'h42;
            e.pos    = i - 1;
            exp_q.push_back(e);
        end
        return errs;
    endfunction

    task automatic do_reset();
        @(posedge clkIn);
        #1 rstIn = 1'b1;
        validIn = 1'b0;
        lastIn  = 1'b0;
        repeat (2) @(posedge clkIn);
        #1 rstIn = 1'b0;
        obs0.delete();
        obs1.delete();
        acc_cyc.delete();
        sb.delete();
        sl.delete();
    endtask

    task automatic drive(input int gap, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            while ($urandom_range(99) < gap) begin
                @(posedge clkIn);
                #1 validIn = 1'b0;
                lastIn = 1'b0;
                dataIn = 8'($urandom);
            end
            @(posedge clkIn);
            #1 validIn = 1'b1;
            dataIn = sb[k];
            lastIn = sl[k];
        end
        @(posedge clkIn);
        #1 validIn = 1'b0;
        lastIn = 1'b0;
    endtask

    task automatic cmp_dut(input string ph, input int d, input int errs, input logic [63:0] errcnt);
        int   sz = (d == 0) ? obs0.size() : obs1.size();
        ev_t  o, e;
        chk($sformatf("%s d%0d count", ph, d), 64'(sz), 64'(exp_q.size()));
        for (int k = 0; k < sz && k < exp_q.size(); k++) begin
            o = (d == 0) ? obs0[k] : obs1[k];
            e = exp_q[k];
            chk($sformatf("%s d%0d ev%0d kind", ph, d, k), 64'(o.kind), 64'(e.kind));
            chk($sformatf("%s d%0d ev%0d ref", ph, d, k), o.refn, e.refn);
            chk($sformatf("%s d%0d ev%0d loc", ph, d, k), 64'(o.loc), 64'(e.loc));
            chk($sformatf("%s d%0d ev%0d price", ph, d, k), 64'(o.price), 64'(e.price));
            chk($sformatf("%s d%0d ev%0d shares", ph, d, k), 64'(o.shares), 64'(e.shares));
            chk($sformatf("%s d%0d ev%0d bs", ph, d, k), 64'(o.bs), 64'(e.bs));
            chk($sformatf("%s d%0d ev%0d cycle", ph, d, k), 64'(o.pos), 64'(acc_cyc[e.pos] + 1));
        end
        chk($sformatf("%s d%0d errcount", ph, d), errcnt, 64'(errs));
    endtask

    task automatic run_check(input string ph, input int gap);
        int e;
        drive(gap, sb.size());
        repeat (4) @(posedge clkIn);
        @(negedge clkIn);
        e = model(1'b1);
        cmp_dut(ph, 0, e > 65535 ? 65535 : e, 64'(err0));
        e = model(1'b0);
        cmp_dut(ph, 1, e > 3 ? 3 : e, 64'(err1));
    endtask

    initial begin
        do_reset();
        @(negedge clkIn);
        chk("reset d0 outputs", 64'(|{a0, d0, x0, ref0, loc0, pr0, sh0, bs0, err0}), 64'd0);
        chk("reset d1 outputs", 64'(|{a1, d1, x1, ref1, loc1, pr1, sh1, bs1, err1}), 64'd0);

        do_reset();
        mk_del(16'($urandom), {$urandom, $urandom});
        emit(-1, 1'b0);
        mk_exec(16'($urandom), {$urandom, $urandom}, 32'd25);
        emit(-1, 1'b1);
        run_check("del_exec", 40);
        if (obs0.size() == 2) begin
            chk("del shares", 64'(obs0[0].shares), 64'd0);
            chk("exec shares", 64'(obs0[1].shares), 64'd25);
            chk("exec price", 64'(obs0[1].price), 64'd0);
        end

        sb.delete();
        sl.delete();
        obs0.delete();
        mk_add(8'h41, 16'h0007, 64'h1122334455667788, 8'h42, 32'd100, 32'h0001E240);
        emit(-1, 1'b0);
        drive(0, 22);
        @(posedge clkIn);
        #1 rstIn = 1'b1;
        @(posedge clkIn);
        @(negedge clkIn);
        chk("in reset d0 outputs", 64'(|{a0, d0, x0, ref0, loc0, pr0, sh0, bs0, err0}), 64'd0);
        chk("in reset d1 outputs", 64'(|{a1, d1, x1, ref1, loc1, pr1, sh1, bs1, err1}), 64'd0);
        @(posedge clkIn);
        #1 rstIn = 1'b0;
        @(negedge clkIn);
        chk("after reset d0 outputs", 64'(|{a0, d0, x0, ref0, loc0, pr0, sh0, bs0, err0}), 64'd0);
        chk("partial add pulses", 64'(obs0.size()), 64'd0);
        obs0.delete();
        obs1.delete();
        acc_cyc.delete();
        sb.delete();
        sl.delete();
        mk_add(8'h41, 16'h0007, 64'h1122334455667788, 8'h42, 32'd100, 32'h0001E240);
        emit(-1, 1'b1);
        run_check("add", 0);
        if (obs0.size() == 1) begin
            chk("add price", 64'(obs0[0].price), 64'h0001E240);
            chk("add shares", 64'(obs0[0].shares), 64'd100);
            chk("add ref", obs0[0].refn, 64'h1122334455667788);
            chk("add buysell", 64'(obs0[0].bs), 64'd1);
        end

        do_reset();
        mk_rand(8'h53, 12);
        emit(-1, 1'b0);
        mk_add(8'h41, 16'd3, {$urandom, $urandom}, 8'h53, 32'($urandom), 32'($urandom));
        void'(mb.pop_back());
        emit(-1, 1'b0);
        mk_add(8'h41, 16'd4, {$urandom, $urandom}, 8'h58, 32'($urandom), 32'($urandom));
        emit(-1, 1'b0);
        mk_add(8'h41, 16'd5, {$urandom, $urandom}, 8'h53, 32'($urandom), 32'($urandom));
        emit(-1, 1'b1);
        run_check("errors", 20);
        chk("errors errcount", 64'(err0), 64'd2);

        do_reset();
        mk_exec(16'($urandom), {$urandom, $urandom}, 32'($urandom));
        emit(10, 1'b0);
        mk_del(16'($urandom), {$urandom, $urandom});
        emit(-1, 1'b1);
        run_check("trunc", 20);
        chk("trunc errcount", 64'(err0), 64'd1);

        do_reset();
        mk_add(8'h46, 16'($urandom), {$urandom, $urandom}, 8'h42, 32'($urandom), 32'($urandom));
        emit(-1, 1'b0);
        mk_add(8'h46, 16'($urandom), {$urandom, $urandom}, 8'h53, 32'($urandom), 32'($urandom));
        emit(-1, 1'b0);
        mk_add(8'h41, 16'($urandom), {$urandom, $urandom}, 8'h42, 32'($urandom), 32'($urandom));
        emit(-1, 1'b1);
        run_check("mpid", 10);
        chk("mpid d1 errcount", 64'(err1), 64'd0);

        do_reset();
        for (int m = 0; m < 80; m++) begin
            int r  = $urandom_range(7);
            int tr = -1;
            case (r)
                0, 1: mk_add(8'h41, 16'($urandom), {$urandom, $urandom},
                             ($urandom_range(7) == 0) ? 8'h58 : ($urandom_range(1) ? 8'h42 : 8'h53),
                             32'($urandom), 32'($urandom));
                2: mk_add(8'h46, 16'($urandom), {$urandom, $urandom},
                          ($urandom_range(7) == 0) ? 8'h58 : 8'h42, 32'($urandom), 32'($urandom));
                3: mk_del(16'($urandom), {$urandom, $urandom});
                4: mk_exec(16'($urandom), {$urandom, $urandom}, 32'($urandom));
                5: mk_rand(8'($urandom), $urandom_range(1, 50));
                6: mk_rand(kts[$urandom_range(3)], $urandom_range(1, 45));
                default: mb.delete();
            endcase
            if (mb.size() >= 2 && $urandom_range(9) == 0) tr = $urandom_range(mb.size() - 2);
            else if ($urandom_range(19) == 0) tr = -2;
            emit(tr, $urandom_range(3) == 0);
        end
        run_check("random", 25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
